// File: rtl/system_widths_pkg.sv
// Shared widths, arbiter FSM states and the latched request record
// for the cache-to-memory arbitration path.
package system_widths_pkg;
    localparam int ADDR_W  = 16;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        write;
    } mem_req_t;
endpackage

// File: rtl/cache_mem_if.sv
// Byte-wide request/response link between a cache (master) and memory (slave).
interface cache_mem_if;
    logic                                mem_req_valid;
    logic                                mem_req_ready;
    logic                                mem_req_we;
    logic [system_widths_pkg::ADDR_W-1:0] mem_req_addr;
    logic [7:0]                          mem_req_write;
    logic [7:0]                          mem_resp_data;
    logic                                mem_resp_valid;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_write,
        input  mem_req_ready, mem_resp_data, mem_resp_valid
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_write,
        output mem_req_ready, mem_resp_data, mem_resp_valid
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way combinational grant: a lone requester always wins, a tie goes to prio.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] & (~valid[1] | ~prio);
    assign grant[1] = valid[1] & (~valid[0] |  prio);
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of one memory port between I-side and D-side caches,
// one transaction in flight, with a response timeout.
module mem_arbiter
    import system_widths_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic      clk,
    input  logic      resetN,
    cache_mem_if.slave  req0_if,
    cache_mem_if.slave  req1_if,
    cache_mem_if.master mem_if,
    output logic      busy,
    output logic      timeout_pulse,
    output logic      owner
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e                       state, state_nxt;
    logic                             prio;
    mem_req_t                         lat;
    logic [CNT_W-1:0]                 cnt;
    logic [NUM_REQ-1:0]               valid, grant, ready, resp_valid;
    mem_req_t [NUM_REQ-1:0]           req;
    logic                             accept, resp_in, expire;
    logic [7:0]                       rdata;

    assign valid  = {req1_if.mem_req_valid, req0_if.mem_req_valid};
    assign req[0] = {req0_if.mem_req_we, req0_if.mem_req_addr, req0_if.mem_req_write};
    assign req[1] = {req1_if.mem_req_we, req1_if.mem_req_addr, req1_if.mem_req_write};

    rr_arbiter2 u_rr (
        .valid (valid),
        .prio  (prio),
        .grant (grant)
    );

    assign ready   = (state == IDLE) ? grant : '0;
    assign accept  = |(valid & ready);
    assign resp_in = (state == WAIT) && mem_if.mem_resp_valid;
    // A real response in the last cycle beats the timeout.
    assign expire  = (state == WAIT) && !mem_if.mem_resp_valid && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!resetN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)                state_nxt = ISSUE;
            ISSUE:   if (mem_if.mem_req_ready)  state_nxt = WAIT;
            WAIT:    if (resp_in || expire)     state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            prio  <= 1'b0;
            owner <= 1'b0;
            lat   <= '0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                lat   <= req[ready[1]];
                owner <= ready[1];
            end
            if (state == ISSUE && mem_if.mem_req_ready) cnt <= '0;
            else if (state == WAIT && cnt != '1)         cnt <= cnt + 1'b1;
            if (resp_in || expire) prio <= ~owner;
        end
    end

    always_comb begin
        busy          = (state != IDLE);
        timeout_pulse = expire;
        resp_valid    = '0;
        if (resp_in || expire) resp_valid[owner] = 1'b1;
        rdata         = resp_in ? mem_if.mem_resp_data : 8'h00;
    end

    assign mem_if.mem_req_valid  = (state == ISSUE);
    assign mem_if.mem_req_we     = lat.we;
    assign mem_if.mem_req_addr   = lat.addr;
    assign mem_if.mem_req_write  = lat.write;

    assign req0_if.mem_req_ready  = ready[0];
    assign req0_if.mem_resp_valid = resp_valid[0];
    assign req0_if.mem_resp_data  = resp_valid[0] ? rdata : 8'h00;
    assign req1_if.mem_req_ready  = ready[1];
    assign req1_if.mem_resp_valid = resp_valid[1];
    assign req1_if.mem_resp_data  = resp_valid[1] ? rdata : 8'h00;

    // Requesters must hold a request until it is accepted.
    hold0: assert property (@(posedge clk) disable iff (!resetN)
        (req0_if.mem_req_valid && !req0_if.mem_req_ready) |=> req0_if.mem_req_valid);
    hold1: assert property (@(posedge clk) disable iff (!resetN)
        (req1_if.mem_req_valid && !req1_if.mem_req_ready) |=> req1_if.mem_req_valid);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus hand-written
// contention, timeout, backpressure and reset sequences against a memory stub.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic resetN;
    logic busy, timeout_pulse, owner;

    always #5 clk = ~clk;

    cache_mem_if r0 ();
    cache_mem_if r1 ();
    cache_mem_if m ();

    mem_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .req0_if       (r0),
        .req1_if       (r1),
        .mem_if        (m),
        .busy          (busy),
        .timeout_pulse (timeout_pulse),
        .owner         (owner)
    );

    logic [1:0]       v, we;
    logic [1:0][15:0] addr;
    logic [1:0][7:0]  wd;
    logic [1:0]       rdy, rv;
    logic [1:0][7:0]  rd;

    assign r0.mem_req_valid = v[0];
    assign r0.mem_req_we    = we[0];
    assign r0.mem_req_addr  = addr[0];
    assign r0.mem_req_write = wd[0];
    assign r1.mem_req_valid = v[1];
    assign r1.mem_req_we    = we[1];
    assign r1.mem_req_addr  = addr[1];
    assign r1.mem_req_write = wd[1];
    assign rdy = {r1.mem_req_ready, r0.mem_req_ready};
    assign rv  = {r1.mem_resp_valid, r0.mem_resp_valid};
    assign rd  = {r1.mem_resp_data, r0.mem_resp_data};

    // Memory stub: responds one cycle after a request handshake; resp_en can
    // hold the response back, flush clears it and reloads the preset contents.
    logic       mem_rdy, resp_en, flush, pend;
    logic [7:0] pdata;
    logic [7:0] mem [256];

    assign m.mem_req_ready  = mem_rdy;
    assign m.mem_resp_valid = pend & resp_en;
    assign m.mem_resp_data  = pdata;

    always @(posedge clk) begin
        if (flush) begin
            pend  <= 1'b0;
            pdata <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h01] <= 8'h11;
            mem[8'h02] <= 8'h22;
            mem[8'h10] <= 8'hA5;
            mem[8'hFF] <= 8'hC3;
        end else if (m.mem_req_valid && mem_rdy) begin
            pend  <= 1'b1;
            pdata <= m.mem_req_we ? m.mem_req_write : mem[m.mem_req_addr[7:0]];
            if (m.mem_req_we) mem[m.mem_req_addr[7:0]] <= m.mem_req_write;
        end else if (pend && resp_en) begin
            pend <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Single uncontended transaction from requester r: accept T, issue T+1, response T+2.
    task automatic do_txn(input int r, input logic w, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:0] exp, input string tag);
        v[r] = 1'b1; we[r] = w; addr[r] = a; wd[r] = d;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(rdy[r]), 1);
        chk({tag, "_ready_other"}, 32'(rdy[1-r]), 0);
        @(posedge clk); #1 v[r] = 1'b0;
        @(negedge clk);
        chk({tag, "_mem_valid"}, 32'(m.mem_req_valid), 1);
        chk({tag, "_mem_addr"}, 32'(m.mem_req_addr), 32'(a));
        chk({tag, "_mem_we"}, 32'(m.mem_req_we), 32'(w));
        if (w) chk({tag, "_mem_write"}, 32'(m.mem_req_write), 32'(d));
        chk({tag, "_owner"}, 32'(owner), 32'(r));
        chk({tag, "_busy"}, 32'(busy), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_resp_valid"}, 32'(rv[r]), 1);
        chk({tag, "_resp_other"}, 32'(rv[1-r]), 0);
        chk({tag, "_resp_data"}, 32'(rd[r]), 32'(exp));
        @(posedge clk); #1;
    endtask

    // Both requesters keep loads of 0x01 / 0x02 pending; each drops valid after
    // its last accept. Grants must alternate and come 3 cycles apart.
    task automatic run_both(input int n0, input int n1, input int first, input string tag);
        int rem [2];
        int exp_g, last, nresp, cyc, g;
        rem[0] = n0; rem[1] = n1;
        exp_g = first; last = -1; nresp = 0; cyc = 0;
        we = 2'b00; addr[0] = 16'h0001; addr[1] = 16'h0002; wd = '0;
        v = 2'b11;
        while (nresp < n0 + n1 && cyc < 60) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rv[i]) begin
                    chk({tag, "_data"}, 32'(rd[i]), (i == 0) ? 32'h11 : 32'h22);
                    nresp++;
                end
            end
            g = -1;
            if (v[0] && rdy[0])      g = 0;
            else if (v[1] && rdy[1]) g = 1;
            if (g >= 0) begin
                chk({tag, "_one_ready"}, 32'(rdy[0] & rdy[1]), 0);
                chk({tag, "_grant"}, g, exp_g);
                if (last >= 0) chk({tag, "_gap"}, cyc - last, 3);
                last = cyc;
                rem[g]--;
                exp_g = (rem[1-g] > 0) ? 1 - g : g;
            end
            @(posedge clk); #1;
            if (g >= 0 && rem[g] == 0) v[g] = 1'b0;
            cyc++;
        end
        chk({tag, "_resp_count"}, nresp, n0 + n1);
        v = 2'b00;
    endtask

    typedef struct {
        int         r;
        logic       w;
        logic [15:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 1'b0, 16'h0010, 8'h00, 8'hA5};
        tbl[1] = '{1, 1'b1, 16'h0020, 8'h3C, 8'h3C};
        tbl[2] = '{0, 1'b0, 16'h0020, 8'h00, 8'h3C};
        tbl[3] = '{1, 1'b0, 16'h0010, 8'h00, 8'hA5};
        tbl[4] = '{0, 1'b1, 16'h0030, 8'h77, 8'h77};
        tbl[5] = '{1, 1'b0, 16'h0030, 8'h00, 8'h77};
        tbl[6] = '{1, 1'b0, 16'hFFFF, 8'h00, 8'hC3};
        tbl[7] = '{0, 1'b0, 16'h0000, 8'h00, 8'h00};

        resetN = 1'b0; flush = 1'b1; mem_rdy = 1'b1; resp_en = 1'b1;
        v = '0; we = '0; addr = '0; wd = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout_pulse), 0);
        chk("rst_mem_valid", 32'(m.mem_req_valid), 0);
        chk("rst_resp_valid", 32'(rv), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_fields", 32'({m.mem_req_we, m.mem_req_addr, m.mem_req_write}), 0);
        @(posedge clk); #1;
        resetN = 1'b1; flush = 1'b0;

        run_both(2, 2, 0, "contend");

        for (int i = 0; i < 8; i++)
            do_txn(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp, $sformatf("vec%0d", i));

        // Timeout: memory never answers, owner gets 0x00 on the 8th WAIT cycle.
        resp_en = 1'b0;
        v[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0040;
        @(negedge clk);
        chk("to_ready", 32'(rdy[1]), 1);
        @(posedge clk); #1 v[1] = 1'b0;
        @(negedge clk);
        chk("to_issue", 32'(m.mem_req_valid), 1);
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) begin
                chk("to_quiet_resp", 32'(rv), 0);
                chk("to_quiet_pulse", 32'(timeout_pulse), 0);
            end else begin
                chk("to_resp_valid", 32'(rv), 32'b10);
                chk("to_resp_data", 32'(rd[1]), 0);
                chk("to_pulse", 32'(timeout_pulse), 1);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_idle", 32'(busy), 0);
        chk("to_pulse_end", 32'(timeout_pulse), 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; resp_en = 1'b1;
        do_txn(0, 1'b0, 16'h0010, 8'h00, 8'hA5, "after_to");

        // Response arriving in the very cycle the timeout would fire.
        resp_en = 1'b0;
        v[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
        @(posedge clk); #1 v[0] = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) resp_en = 1'b1;
            @(negedge clk);
            if (k == 8) begin
                chk("tie_resp_valid", 32'(rv), 32'b01);
                chk("tie_resp_data", 32'(rd[0]), 32'hA5);
                chk("tie_pulse", 32'(timeout_pulse), 0);
            end
            @(posedge clk); #1;
        end

        // Backpressure: memory not ready for 5 issue cycles.
        mem_rdy = 1'b0;
        v[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0080; wd[1] = 8'h99;
        @(posedge clk); #1 v[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(m.mem_req_valid), 1);
            chk("bp_fields", 32'({m.mem_req_we, m.mem_req_addr, m.mem_req_write}), 32'h1_0080_99);
            chk("bp_resp", 32'(rv), 0);
            @(posedge clk); #1;
        end
        mem_rdy = 1'b1;
        @(negedge clk);
        chk("bp_valid_last", 32'(m.mem_req_valid), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_resp_valid", 32'(rv), 32'b10);
        chk("bp_resp_data", 32'(rd[1]), 32'h99);
        @(posedge clk); #1;
        do_txn(0, 1'b0, 16'h0080, 8'h00, 8'h99, "bp_readback");

        // Reset during WAIT of a req1 load (priority was pointing at req1).
        resp_en = 1'b0;
        v[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0020;
        @(posedge clk); #1 v[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_busy_before", 32'(busy), 1);
        resetN = 1'b0;
        @(posedge clk); #1 resetN = 1'b1;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_owner", 32'(owner), 0);
        chk("mid_mem_valid", 32'(m.mem_req_valid), 0);
        resp_en = 1'b1;
        #1;
        chk("mid_late_resp", 32'(rv), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_late_resp2", 32'(rv), 0);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        run_both(1, 1, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
